fft_peak_detect: RTL and testbench

Streaming consumer placed directly downstream of the FFT core's source interface (valid/sop/eop/real/imag). Per frame, it computes |X[k]|^2 for every bin and tracks the maximum over the positive-frequency half, excluding the low bins (DC). At end of frame it reports the peak bin index and its magnitude-squared, for use by the sqrt/cordic post-processing and by display logic.

---
 rtl/fft_pkg.sv | 18 +
 rtl/mag_sq_pipe.sv | 61 ++++++
 rtl/fft_peak_detect.sv | 227 ++++++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT peak detector.
// Default geometry: 12-bit signed bins, 4096-point frames, DC bin rejected.
package fft_pkg;

  localparam int DEF_DW      = 12;
  localparam int DEF_AW      = 12;
  localparam int DEF_NPTS    = 2 ** DEF_AW;
  localparam int DEF_SKIP_LO = 1;
  localparam int DEF_MAG_W   = 2 * DEF_DW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } fft_state_t;

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage magnitude-squared pipe: stage A squares re and im, stage B sums
// them into an unsigned 2*DW+1 result. The valid bit and bin index travel
// alongside, so the block also serves the RAM-readback magnitude path.
module mag_sq_pipe
  import fft_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic [AW-1:0]        in_idx,
  output logic                 out_valid,
  output logic [2*DW:0]        out_mag,
  output logic [AW-1:0]        out_idx
);

  logic signed [2*DW-1:0] re_x;
  logic signed [2*DW-1:0] im_x;
  logic signed [2*DW-1:0] p_re;
  logic signed [2*DW-1:0] p_im;
  logic                   a_valid;
  logic [AW-1:0]          a_idx;

  // Sign-extend before multiplying so the product is computed at full width.
  assign re_x = {{DW{in_re[DW-1]}}, in_re};
  assign im_x = {{DW{in_im[DW-1]}}, in_im};

  // Stage A: squares of real and imaginary parts.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      a_valid <= 1'b0;
      a_idx   <= '0;
      p_re    <= '0;
      p_im    <= '0;
    end else begin
      a_valid <= in_valid;
      a_idx   <= in_idx;
      p_re    <= re_x * re_x;
      p_im    <= im_x * im_x;
    end
  end

  // Stage B: squares are non-negative, so an unsigned add with one extra bit
  // holds the worst case (-2^(DW-1))^2 * 2 without overflow.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_mag   <= '0;
    end else begin
      out_valid <= a_valid;
      out_idx   <= a_idx;
      out_mag   <= {1'b0, p_re} + {1'b0, p_im};
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame spectral peak detector sitting on the FFT source interface.
// Computes |X[k]|^2 per bin, tracks the maximum over bins SKIP_LO..NPTS/2-1
// and reports bin index and magnitude-squared after each well-formed frame.
// Optional build macro FFT_PEAK_THRESH_EN adds mag_thresh/no_peak: a peak
// below threshold is reported as no_peak instead of peak_valid.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | ready, waiting for a beat with in_sop
//   ACC    | accepting bins, counting index, checking frame shape
//   FLUSH  | not ready, 3 cycles for the magnitude/compare pipe to drain
//   REPORT | publish the running maximum, then back to IDLE
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int SKIP_LO = DEF_SKIP_LO
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 in_ready,
  output logic                 peak_valid,
  output logic [AW-1:0]        peak_bin,
  output logic [2*DW:0]        peak_mag,
  output logic                 frame_err,
`ifdef FFT_PEAK_THRESH_EN
  input  logic [2*DW:0]        mag_thresh,
  output logic                 no_peak,
`endif
  output logic                 busy
);

  localparam int             NPTS     = 2 ** AW;
  localparam int             MAG_W    = 2 * DW + 1;
  localparam logic [AW-1:0]  LAST_IDX = '1;
  localparam logic [AW-1:0]  LO_IDX   = AW'(SKIP_LO);
  localparam logic [AW-1:0]  HI_IDX   = AW'(NPTS / 2 - 1);

  fft_state_t          state;
  logic [AW-1:0]       cnt;
  logic [1:0]          flush_cnt;
  logic                beat;
  logic [AW-1:0]       beat_idx;

  logic                s1_valid;
  logic                s1_sop;
  logic signed [DW-1:0] s1_re;
  logic signed [DW-1:0] s1_im;
  logic [AW-1:0]       s1_idx;
  logic                sop_a;
  logic                sop_b;

  logic                m_valid;
  logic [MAG_W-1:0]    m_mag;
  logic [AW-1:0]       m_idx;
  logic                considered;

  logic                max_vld;
  logic [MAG_W-1:0]    max_mag;
  logic [AW-1:0]       max_idx;

  assign beat     = in_valid && in_ready;
  // A sop always restarts indexing; otherwise the beat follows the last one.
  assign beat_idx = (in_sop || state != ACC) ? '0 : cnt + 1'b1;

  // Frame sequencing, shape checking and result publication.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_cnt  <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      frame_err  <= 1'b0;
`ifdef FFT_PEAK_THRESH_EN
      no_peak    <= 1'b0;
`endif
    end else begin
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef FFT_PEAK_THRESH_EN
      no_peak    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (beat && in_sop) begin
            cnt <= '0;
            if (in_eop) begin
              // single-beat frame is malformed
              frame_err <= 1'b1;
            end else begin
              state <= ACC;
              busy  <= 1'b1;
            end
          end
        end
        ACC: begin
          if (beat) begin
            cnt <= beat_idx;
            if (in_sop) begin
              frame_err <= 1'b1;
              if (in_eop) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (in_eop && beat_idx == LAST_IDX) begin
              state     <= FLUSH;
              in_ready  <= 1'b0;
              flush_cnt <= 2'd2;
            end else if (in_eop || beat_idx == LAST_IDX) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        FLUSH: begin
          in_ready <= 1'b0;
          if (flush_cnt == 2'd0) begin
            state <= REPORT;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        REPORT: begin
`ifdef FFT_PEAK_THRESH_EN
          if (max_mag < mag_thresh) begin
            no_peak <= 1'b1;
          end else begin
            peak_valid <= 1'b1;
            peak_bin   <= max_idx;
            peak_mag   <= max_mag;
          end
`else
          peak_valid <= 1'b1;
          peak_bin   <= max_idx;
          peak_mag   <= max_mag;
`endif
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // S1: capture accepted beats that belong to a frame; stray IDLE beats drop.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= beat && (state == ACC || in_sop);
      s1_sop   <= in_sop;
      s1_re    <= in_re;
      s1_im    <= in_im;
      s1_idx   <= beat_idx;
    end
  end

  // Carry the sop marker beside the magnitude pipe so the running max clears
  // exactly when the new frame's first bin arrives, after old bins drain.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sop_a <= 1'b0;
      sop_b <= 1'b0;
    end else begin
      sop_a <= s1_valid && s1_sop;
      sop_b <= sop_a;
    end
  end

  mag_sq_pipe #(
    .DW (DW),
    .AW (AW)
  ) u_mag_sq_pipe (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (s1_valid),
    .in_re     (s1_re),
    .in_im     (s1_im),
    .in_idx    (s1_idx),
    .out_valid (m_valid),
    .out_mag   (m_mag),
    .out_idx   (m_idx)
  );

  assign considered = m_valid && (m_idx >= LO_IDX) && (m_idx <= HI_IDX);

  // S3 compare: strict greater-than so ties keep the lower bin; the first
  // considered bin of a frame always loads, even at zero magnitude.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      max_vld <= 1'b0;
      max_mag <= '0;
      max_idx <= '0;
    end else if (m_valid && sop_b) begin
      max_vld <= considered;
      max_mag <= considered ? m_mag : '0;
      max_idx <= considered ? m_idx : '0;
    end else if (considered && (!max_vld || m_mag > max_mag)) begin
      max_vld <= 1'b1;
      max_mag <= m_mag;
      max_idx <= m_idx;
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: stimulus pushes expected events,
// a negedge monitor pops and compares whenever peak_valid or frame_err fires.
module tb_fft_peak_detect;

  localparam int DW   = 12;
  localparam int AW   = 12;
  localparam int NPTS = 4096;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sop = 1'b0;
  logic                 in_eop = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 in_ready;
  logic                 peak_valid;
  logic [AW-1:0]        peak_bin;
  logic [2*DW:0]        peak_mag;
  logic                 frame_err;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int     kind;   // 0 = peak report, 1 = frame error
    int     bin;
    longint mag;
    int     cyc;
  } ev_t;
  ev_t q[$];

  logic signed [DW-1:0] re_mem[NPTS];
  logic signed [DW-1:0] im_mem[NPTS];

  fft_peak_detect dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_ready   (in_ready),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int bin, input longint mag, input int c);
    ev_t e;
    e.kind = kind;
    e.bin  = bin;
    e.mag  = mag;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      chk(kind == 0 ? "unexpected_peak_valid" : "unexpected_frame_err", 1, 0);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == 0 && e.kind == 0) begin
        chk("peak_bin", peak_bin, e.bin);
        chk("peak_mag", peak_mag, e.mag);
      end
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      if (frame_err)  check_ev(1);
      if (peak_valid) check_ev(0);
    end
  end

  task automatic send_beat(input bit sop, input bit eop,
                           input logic signed [DW-1:0] re,
                           input logic signed [DW-1:0] im,
                           output int edge_no);
    bit rdy;
    bit done;
    int n;
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_re    = re;
    in_im    = im;
    edge_no  = -1;
    done     = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge sys_clk);
      rdy = in_ready;
      n   = cyc;
      @(posedge sys_clk);
      #1;
      if (rdy) begin
        edge_no = n + 1;
        done    = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    if (!done) chk("in_ready_timeout", 0, 1);
  endtask

  // last_kind: 0 nothing expected, 1 peak 4 cycles after last beat,
  // 2 frame_err on the last beat.
  task automatic frame(input int len, input bit eop_last, input bit err_first,
                       input int last_kind, input int eb, input longint em);
    int e;
    for (int i = 0; i < len; i++) begin
      if (i % 97 == 50) begin
        @(posedge sys_clk);
        #1;
      end
      send_beat(i == 0, eop_last && (i == len - 1), re_mem[i], im_mem[i], e);
      if (i == 0 && err_first) push(1, 0, 0, e);
      if (i == len - 1) begin
        if (last_kind == 1) push(0, eb, em, e + 4);
        else if (last_kind == 2) push(1, 0, 0, e);
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NPTS; i++) begin
      re_mem[i] = '0;
      im_mem[i] = '0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_peak_valid"}, peak_valid, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
    chk({tag, "_peak_mag"}, peak_mag, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int e;
    clear_mem();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs_zero("reset");
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;

    // stray beats without sop in IDLE are ignored
    for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 12'sd500, 12'sd500, e);

    // 1: single tone at bin 100
    clear_mem();
    re_mem[100] = 12'sd1000;
    frame(NPTS, 1'b1, 1'b0, 1, 100, 1000000);

    // 2: tie between bins 50 and 200 keeps the lower index
    clear_mem();
    re_mem[50] = 12'sd300;  im_mem[50] = -12'sd400;
    re_mem[200] = 12'sd300; im_mem[200] = -12'sd400;
    frame(NPTS, 1'b1, 1'b0, 1, 50, 250000);

    // 3: DC and upper half ignored
    clear_mem();
    re_mem[0] = 12'sd2047;
    re_mem[3000] = 12'sd2000;
    re_mem[7] = 12'sd10; im_mem[7] = 12'sd10;
    frame(NPTS, 1'b1, 1'b0, 1, 7, 200);

    // 4: full-scale negative corner
    clear_mem();
    re_mem[9] = -12'sd2048; im_mem[9] = -12'sd2048;
    frame(NPTS, 1'b1, 1'b0, 1, 9, 8388608);

    // 5: short frame, then a good frame with peak on the last searched bin
    clear_mem();
    re_mem[40] = 12'sd1500;
    frame(101, 1'b1, 1'b0, 2, 0, 0);
    clear_mem();
    re_mem[1] = 12'sd3;
    re_mem[1500] = -12'sd7;
    re_mem[2047] = -12'sd8; im_mem[2047] = 12'sd1;
    re_mem[2048] = 12'sd100;
    frame(NPTS, 1'b1, 1'b0, 1, 2047, 65);

    // 6: sop mid-frame discards the partial frame
    clear_mem();
    re_mem[10] = 12'sd2000;
    frame(2000, 1'b0, 1'b0, 0, 0, 0);
    clear_mem();
    re_mem[1] = 12'sd1; im_mem[1] = 12'sd1;
    im_mem[20] = -12'sd30;
    frame(NPTS, 1'b1, 1'b1, 1, 20, 900);

    // reset in the middle of a frame: everything back to 0, no pulses
    clear_mem();
    re_mem[30] = 12'sd900;
    frame(500, 1'b0, 1'b0, 0, 0, 0);
    @(negedge sys_clk);
    chk("busy_mid_frame", busy, 1);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_outputs_zero("midreset");
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;

    // all-zero frame reports the first searched bin with zero magnitude
    clear_mem();
    frame(NPTS, 1'b1, 1'b0, 1, 1, 0);

    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge sys_clk);
    repeat (5) @(negedge sys_clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
